prio_arb_w8_rr: RTL and testbench

PRIO_ARB_W8_RR -- requirements
Module: prio_arb_w8_rr

---
 rtl/prio_arb_w8_rr_pkg.sv | 26 ++
 rtl/prio_enc_w8_t2.sv | 50 +++++
 rtl/prio_arb_w8_rr.sv | 118 +++++++++++
 tb/tb_prio_arb_w8_rr.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/prio_arb_w8_rr_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Holds the FSM encoding, encoder codes and rotate helper.
package prio_arb_w8_rr_pkg;

    localparam int NUM_REQ = 8;
    localparam logic [3:0] ENC_NONE = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        GRANT = 2'd3
    } state_t;

    // Bit i of the result is req[(i + ptr) mod 8].
    function automatic logic [7:0] rot_right(
        input logic [7:0] req,
        input logic [2:0] ptr
    );
        logic [15:0] dbl;
        dbl = {req, req};
        dbl = dbl >> ptr;
        return dbl[7:0];
    endfunction

endpackage

// File: rtl/prio_enc_w8_t2.sv
// 8:4 lowest-set-bit priority encoder, two register stages.
// Code 8 means no bit set; the pipeline carries no reset.
module prio_enc_w8_t2
    import prio_arb_w8_rr_pkg::*;
#(
    parameter bit SIM_EMULATE = 1'b0
) (
    input  logic       clk,
    input  logic [7:0] din,
    output logic [3:0] dout
);

    logic [7:0] din_q;
    logic [3:0] code;

    generate
        if (SIM_EMULATE) begin : g_emu
            // Behavioural scan: the lowest set bit is the last one written.
            always_comb begin
                code = ENC_NONE;
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (din_q[i]) code = 4'(i);
                end
            end
        end else begin : g_enc
            // Explicit priority table, bit 0 highest.
            always_comb begin
                code = ENC_NONE;
                casez (din_q)
                    8'b???????1: code = 4'd0;
                    8'b??????10: code = 4'd1;
                    8'b?????100: code = 4'd2;
                    8'b????1000: code = 4'd3;
                    8'b???10000: code = 4'd4;
                    8'b??100000: code = 4'd5;
                    8'b?1000000: code = 4'd6;
                    8'b10000000: code = 4'd7;
                    default:     code = ENC_NONE;
                endcase
            end
        end
    endgenerate

    // Input stage then output stage: din in cycle n, dout in n+2.
    always_ff @(posedge clk) begin
        din_q <= din;
        dout  <= code;
    end

endmodule

// File: rtl/prio_arb_w8_rr.sv
// 8-requester round-robin arbiter with bounded grant hold.
// Rotated requests go through a 2-cycle encoder before granting.
module prio_arb_w8_rr
    import prio_arb_w8_rr_pkg::*;
#(
    parameter bit SIM_EMULATE = 1'b0,
    parameter int MAX_HOLD    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       busy
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [7:0] rot_r, rot_nx;
    logic [7:0] hold, hold_nx;
    logic       phase, phase_nx;
    logic [7:0] gnt_nx;
    logic [2:0] id_nx;
    logic       vld_nx;
    logic       busy_nx;
    logic [3:0] dout;
    logic [2:0] win;

    prio_enc_w8_t2 #(
        .SIM_EMULATE(SIM_EMULATE)
    ) u_enc (
        .clk  (clk),
        .din  (rot_r),
        .dout (dout)
    );

    // Next-state and registered-output values for the arbitration FSM.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        rot_nx   = rot_r;
        hold_nx  = hold;
        phase_nx = phase;
        gnt_nx   = gnt;
        id_nx    = gnt_id;
        vld_nx   = gnt_vld;
        win      = 3'(dout[2:0] + ptr);
        unique case (state)
            IDLE: begin
                if (|req) begin
                    rot_nx   = rot_right(req, ptr);
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                phase_nx = 1'b0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (!phase) begin
                    phase_nx = 1'b1;
                end else begin
                    phase_nx = 1'b0;
                    if (dout == ENC_NONE) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = GRANT;
                        gnt_nx   = 8'(1) << win;
                        id_nx    = win;
                        vld_nx   = 1'b1;
                        hold_nx  = 8'd1;
                    end
                end
            end
            GRANT: begin
                if (!req[gnt_id] || hold == HOLD_MAX) begin
                    ptr_nx   = 3'(gnt_id + 3'd1);
                    state_nx = IDLE;
                    gnt_nx   = '0;
                    vld_nx   = 1'b0;
                    hold_nx  = '0;
                end else begin
                    hold_nx = hold + 8'd1;
                end
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            rot_r   <= '0;
            hold    <= '0;
            phase   <= 1'b0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            rot_r   <= rot_nx;
            hold    <= hold_nx;
            phase   <= phase_nx;
            gnt     <= gnt_nx;
            gnt_id  <= id_nx;
            gnt_vld <= vld_nx;
            busy    <= busy_nx;
        end
    end

endmodule

// File: tb/tb_prio_arb_w8_rr.sv
// Directed bench for the round-robin arbiter.
// Checks grant timing, rotation, hold limit and reset behaviour.
module tb_prio_arb_w8_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    prio_arb_w8_rr #(
        .SIM_EMULATE(1'b0),
        .MAX_HOLD   (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_gnt(input string tag, input logic [7:0] g,
                           input logic [2:0] id);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(g != 8'h00));
        if (g != 8'h00) chk({tag, ".id"}, 32'(gnt_id), 32'(id));
    endtask

    // Grant invariants on every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("inv.onehot", 32'($onehot0(gnt)), 32'd1);
            chk("inv.vld", 32'(gnt_vld), 32'(|gnt));
            if (gnt_vld) chk("inv.id", 32'(gnt[gnt_id]), 32'd1);
        end
    end

    initial begin
        int held;
        logic [2:0] w;

        run(2);
        chk_gnt("rst", 8'h00, 3'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.id", 32'(gnt_id), 32'd0);

        // Single request: grant at c4, drop at c6, idle at c7.
        rst_n = 1'b1;
        req   = 8'h01;
        tick();
        chk("r1.busy", 32'(busy), 32'd1);
        chk_gnt("r1.c1", 8'h00, 3'd0);
        run(2);
        chk_gnt("r1.c3", 8'h00, 3'd0);
        tick();
        chk_gnt("r1.c4", 8'h01, 3'd0);
        run(2);
        chk_gnt("r1.c6", 8'h01, 3'd0);
        req = 8'h00;
        tick();
        chk_gnt("r1.c7", 8'h00, 3'd0);
        chk("r1.idle", 32'(busy), 32'd0);

        // All requesting: ptr is 1, rotate 1..7,0,1 with 16-cycle holds.
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            w = 3'((k + 1) % 8);
            run(4);
            chk_gnt("rr.first", 8'(1) << w, w);
            held = 1;
            repeat (15) begin
                tick();
                if (gnt == (8'(1) << w)) held++;
            end
            chk("rr.held", 32'(held), 32'd16);
            tick();
            chk_gnt("rr.gap", 8'h00, 3'd0);
        end
        req = 8'h00;

        // One-cycle pulse on requester 4 still gets one grant cycle.
        tick();
        req = 8'h10;
        tick();
        req = 8'h00;
        run(2);
        chk_gnt("pl.c3", 8'h00, 3'd0);
        tick();
        chk_gnt("pl.c4", 8'h10, 3'd4);
        tick();
        chk_gnt("pl.c5", 8'h00, 3'd0);
        chk("pl.busy", 32'(busy), 32'd0);

        // Pulse on requester 5 moves ptr to 6.
        req = 8'h20;
        tick();
        req = 8'h00;
        run(3);
        chk_gnt("p5.c4", 8'h20, 3'd5);
        tick();
        chk_gnt("p5.c5", 8'h00, 3'd0);

        // ptr=6, req=41: winner 6, then 0, then 6 again.
        req = 8'h41;
        run(4);
        chk_gnt("ns.w6", 8'h40, 3'd6);
        run(15);
        chk_gnt("ns.w6end", 8'h40, 3'd6);
        tick();
        chk_gnt("ns.gap", 8'h00, 3'd0);
        run(4);
        chk_gnt("ns.w0", 8'h01, 3'd0);
        req = 8'h40;
        tick();
        chk_gnt("ns.rel", 8'h00, 3'd0);
        run(4);
        chk_gnt("ns.w6b", 8'h40, 3'd6);
        req = 8'h00;
        tick();
        chk_gnt("ns.done", 8'h00, 3'd0);

        // Reset during grant of requester 3.
        req = 8'h08;
        run(4);
        chk_gnt("rs.w3", 8'h08, 3'd3);
        tick();
        chk_gnt("rs.hold", 8'h08, 3'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("rs.gnt", 32'(gnt), 32'h0);
        chk("rs.vld", 32'(gnt_vld), 32'd0);
        chk("rs.busy", 32'(busy), 32'd0);
        req = 8'h0C;
        tick();
        rst_n = 1'b1;
        run(3);
        chk_gnt("rs.c3", 8'h00, 3'd0);
        tick();
        chk_gnt("rs.w2", 8'h04, 3'd2);
        req = 8'h00;
        tick();
        chk_gnt("rs.rel", 8'h00, 3'd0);

        // ptr is 3 here; a reset pulse must bring it back to 0.
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req = 8'h81;
        run(4);
        chk_gnt("pz.w0", 8'h01, 3'd0);
        req = 8'h00;
        tick();
        chk_gnt("pz.rel", 8'h00, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
